ram_bank: RTL and testbench
===========================

Name: ram_bank

Overview:
- Parametrised single-port synchronous RAM. Successor to the fixed 32-bit, 1024-word data RAM.
- Adds configurable width and depth, byte-lane write strobes, a registered read with a req/ready/rvalid handshake, error flagging, and an optional post-reset zero-clear sweep.
- Sits behind the core's load/store unit as data or scratch memory; one access per cycle.

Parameters:
DATA_W, 32, word width in bits; power of 2, at least 8.
DEPTH, 1024, number of words; power of 2.
ADDR_W, 32, byte-address width on adr.
INIT_CLEAR, 1, 1 = zero every word after reset before accepting requests; 0 = no sweep, memory contents undefined.
WRITE_FIRST, 0, 0 = a write returns the old word on rdata; 1 = a write returns the newly written word.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
req  in  1  access request; qualified by ready.
we  in  1  1 = write, 0 = read.
be  in  DATA_W/8  byte-lane write strobes; bit k covers wdata[8k+7:8k].
adr  in  ADDR_W  byte address.
wdata  in  DATA_W  write data.
ready  out  1  block can accept a request this cycle.
rvalid  out  1  one-cycle pulse: response for the access accepted on the previous cycle.
rdata  out  DATA_W  response data; held between responses.
err  out  1  qualified by rvalid; the accepted access was rejected.

Behaviour:
- Address decode:
  - OFF_W = log2(DATA_W/8); IDX_W = log2(DEPTH).
  - Word index = adr[OFF_W+IDX_W-1:OFF_W].
  - Misaligned: adr[OFF_W-1:0] != 0.
  - Out of range: any adr bit at or above OFF_W+IDX_W is nonzero.
- Reset, asynchronous, effective immediately on rst_n low:
  - ready=0, rvalid=0, err=0, rdata=0.
  - State goes to INIT (INIT_CLEAR=1) or RUN (INIT_CLEAR=0).
  - Sweep counter goes to 0.
- State INIT:
  - Each cycle writes 0 to word[cnt] and increments cnt.
  - After writing word DEPTH-1 the next state is RUN; the sweep takes exactly DEPTH cycles after reset release.
  - ready=0 throughout; req is ignored.
- State RUN:
  - ready=1 every cycle; no back-pressure.
  - An access is accepted when req=1 in a cycle with ready=1.
- Accepted read:
  - At the next edge, rdata=word[idx], rvalid=1, err=0.
  - Latency is 1 cycle.
- Accepted write:
  - At the same edge, every lane with be[k]=1 is updated; other lanes keep their value.
  - The next cycle has rvalid=1, err=0.
  - rdata is the pre-write word when WRITE_FIRST=0, or the post-write merged word when WRITE_FIRST=1.
  - be all zero: no storage change, still acknowledged normally.
- Misaligned or out-of-range access:
  - No storage change; the next cycle has rvalid=1, err=1, rdata=0.
- Handshake timing:
  - rvalid drops to 0 on any cycle that follows a cycle with no accepted request.
  - Back-to-back accepted requests produce back-to-back rvalid pulses, in order.
- rdata and err hold their last values until the next response.
- Reset mid-sweep: the sweep restarts at word 0.
- Reset with a response pending: that response is dropped and rvalid stays 0.
- Write then read of the same word on consecutive cycles: the read returns the written data; no hazard.

Test Plan:
- Reset release, INIT_CLEAR=1, DEPTH=16 -> ready=0 for exactly 16 cycles, then 1; a read of every word returns 0 with err=0.
- Write adr=0x8, wdata=0xDEADBEEF, be=4'hF; next cycle read adr=0x8 -> read rvalid one cycle after acceptance, rdata=0xDEADBEEF.
- Write adr=0x8, wdata=0x11223344, be=4'b0101, onto word 0xDEADBEEF -> a following read returns 0xDE22BE44. The write response rdata is 0xDEADBEEF with WRITE_FIRST=0, or 0xDE22BE44 with WRITE_FIRST=1.
- Read adr=0x6 (misaligned) and read adr=0x40 (DEPTH=16, out of range) -> rvalid=1, err=1, rdata=0 for each; storage unchanged.
- Continuous req for 8 cycles, alternating write and read to the same word -> 8 consecutive rvalid pulses, each read seeing the preceding write.
- Assert rst_n=0 at sweep count 5, or with a read response pending -> outputs zero immediately; the sweep restarts at 0; no stray rvalid.

Source files
------------

// File: rtl/ram_bank.sv
// Single-port synchronous RAM bank with byte-lane writes, registered response
// handshake, address error flagging and an optional post-reset zero sweep.
module ram_bank #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 32,
  parameter int INIT_CLEAR  = 1,
  parameter int WRITE_FIRST = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   adr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned HI_W  = OFF_W + IDX_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             r_state;
  state_t             w_nstate;
  logic [IDX_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic               r_rvalid;
  logic               r_err;
  logic [DATA_W-1:0]  r_rdata;

  logic               w_ready;
  logic               w_sweep;
  logic               w_acc;
  logic               w_mis;
  logic               w_oor;
  logic               w_bad;
  logic               w_wr;
  logic [IDX_W-1:0]   w_idx;
  logic [DATA_W-1:0]  w_old;
  logic [DATA_W-1:0]  w_merged;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= (INIT_CLEAR != 0) ? S_INIT : S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_sweep) r_cnt <= r_cnt + IDX_W'(1);
    end
  end

  // ready and sweep are gated by rst_n so nothing is accepted or written while reset is held
  always_comb begin
    w_nstate = r_state;
    w_ready  = 1'b0;
    w_sweep  = 1'b0;
    case (r_state)
      S_INIT: begin
        w_sweep = rst_n;
        if (r_cnt == IDX_W'(DEPTH - 1)) w_nstate = S_RUN;
      end
      S_RUN:   w_ready  = rst_n;
      default: w_nstate = S_RUN;
    endcase
  end

  always_comb begin
    w_mis = 1'b0;
    w_oor = 1'b0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      if (i < OFF_W && adr[i]) w_mis = 1'b1;
      if (i >= HI_W && adr[i]) w_oor = 1'b1;
    end
  end

  assign w_idx = adr[OFF_W +: IDX_W];
  assign w_old = r_mem[w_idx];

  always_comb begin
    w_merged = w_old;
    for (int unsigned k = 0; k < BE_W; k++) begin
      if (be[k]) w_merged[8*k +: 8] = wdata[8*k +: 8];
    end
  end

  assign w_acc = req & w_ready;
  assign w_bad = w_mis | w_oor;
  assign w_wr  = w_acc & we & ~w_bad;

  always_ff @(posedge clk) begin
    if (w_sweep)   r_mem[r_cnt] <= '0;
    else if (w_wr) r_mem[w_idx] <= w_merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_acc;
      if (w_acc) begin
        if (w_bad) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end else begin
          r_err   <= 1'b0;
          r_rdata <= (we && WRITE_FIRST != 0) ? w_merged : w_old;
        end
      end
    end
  end

  assign ready  = w_ready;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign err    = r_err;

endmodule

// File: tb/tb_ram_bank.sv
// Self-checking bench for ram_bank (DEPTH=16, 32-bit words, WRITE_FIRST=0)
// against a word-array reference model of the memory and its responses.
module tb_ram_bank;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int WF     = 0;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  be    = '0;
  logic [31:0] adr   = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl [DEPTH];
  logic [31:0] last_rdata = '0;
  logic        last_err   = 1'b0;

  ram_bank #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .INIT_CLEAR(1), .WRITE_FIRST(WF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .adr(adr),
    .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d);
    req = r; we = w; be = b; adr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  // Expected response for an accepted access; updates the model memory.
  task automatic model(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, output logic e, output logic [31:0] rd);
    int unsigned idx;
    logic [31:0] nw;
    if ((a % 4) != 0 || a >= DEPTH * 4) begin
      e  = 1'b1;
      rd = '0;
    end else begin
      idx = a / 4;
      nw  = mdl[idx];
      for (int k = 0; k < 4; k++) if (b[k]) nw[8*k +: 8] = d[8*k +: 8];
      e  = 1'b0;
      rd = (w && WF != 0) ? nw : mdl[idx];
      if (w) mdl[idx] = nw;
    end
    last_rdata = rd;
    last_err   = e;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    last_rdata = '0;
    last_err   = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({ready, rvalid, err, rdata} !== 35'd0) begin
      fails++;
      $display("FAIL reset_outputs: got ready=%b rvalid=%b err=%b rdata=%h, want all 0",
               ready, rvalid, err, rdata);
    end
    model_clear();
    rst_n = 1'b1;
    wait_ready(n);
    tests++;
    if (n != 16) begin
      fails++;
      $display("FAIL sweep_length: ready low for %0d cycles, want 16", n);
    end
  endtask

  task automatic test_clear();
    logic e;
    logic [31:0] rd;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 4'h0, 32'(i * 4), '0);
      model(1'b0, 4'h0, 32'(i * 4), '0, e, rd);
      tests++;
      if ({rvalid, err, rdata} !== {1'b1, e, rd} || rd !== 32'd0) begin
        fails++;
        $display("FAIL clear_read[%0d]: got rvalid=%b err=%b rdata=%h, want 1 0 00000000",
                 i, rvalid, err, rdata);
      end
    end
  endtask

  task automatic test_directed();
    logic e;
    logic [31:0] rd;
    step(1'b1, 1'b1, 4'hF, 32'h8, 32'hDEADBEEF);
    model(1'b1, 4'hF, 32'h8, 32'hDEADBEEF, e, rd);
    tests++;
    if ({rvalid, err, rdata} !== {1'b1, e, rd}) begin
      fails++;
      $display("FAIL write_full_resp: got %b %b %h, want %b %b %h", rvalid, err, rdata, 1'b1, e, rd);
    end
    step(1'b1, 1'b0, 4'h0, 32'h8, '0);
    model(1'b0, 4'h0, 32'h8, '0, e, rd);
    tests++;
    if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL read_full: got %b %b %h, want 1 0 deadbeef", rvalid, err, rdata);
    end
    step(1'b1, 1'b1, 4'b0101, 32'h8, 32'h11223344);
    model(1'b1, 4'b0101, 32'h8, 32'h11223344, e, rd);
    tests++;
    if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL write_lane_resp: got %b %b %h, want 1 0 deadbeef", rvalid, err, rdata);
    end
    step(1'b1, 1'b0, 4'h0, 32'h8, '0);
    model(1'b0, 4'h0, 32'h8, '0, e, rd);
    tests++;
    if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'hDE22BE44}) begin
      fails++;
      $display("FAIL read_lane: got %b %b %h, want 1 0 de22be44", rvalid, err, rdata);
    end
  endtask

  task automatic test_errors();
    logic e;
    logic [31:0] rd;
    logic [31:0] bad_adr [4];
    logic        bad_we  [4];
    bad_adr[0] = 32'h6;  bad_we[0] = 1'b0;
    bad_adr[1] = 32'h40; bad_we[1] = 1'b0;
    bad_adr[2] = 32'hA;  bad_we[2] = 1'b1;
    bad_adr[3] = 32'h48; bad_we[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bad_we[i], 4'hF, bad_adr[i], 32'hFFFFFFFF);
      model(bad_we[i], 4'hF, bad_adr[i], 32'hFFFFFFFF, e, rd);
      tests++;
      if ({rvalid, err, rdata} !== {1'b1, 1'b1, 32'd0}) begin
        fails++;
        $display("FAIL err_resp[adr=%h]: got %b %b %h, want 1 1 00000000",
                 bad_adr[i], rvalid, err, rdata);
      end
    end
    step(1'b1, 1'b0, 4'h0, 32'h8, '0);
    model(1'b0, 4'h0, 32'h8, '0, e, rd);
    tests++;
    if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'hDE22BE44}) begin
      fails++;
      $display("FAIL err_no_store: got %b %b %h, want 1 0 de22be44", rvalid, err, rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    logic [31:0] rd;
    logic        w;
    logic [3:0]  b;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      w = (i % 2) == 0;
      b = 4'($urandom_range(1, 15));
      d = $urandom;
      step(1'b1, w, b, 32'h20, d);
      model(w, b, 32'h20, d, e, rd);
      tests++;
      if ({rvalid, err, rdata} !== {1'b1, e, rd}) begin
        fails++;
        $display("FAIL b2b[%0d]: got %b %b %h, want 1 %b %h", i, rvalid, err, rdata, e, rd);
      end
    end
    step(1'b0, 1'b0, 4'h0, '0, '0);
    tests++;
    if ({rvalid, err, rdata} !== {1'b0, last_err, last_rdata}) begin
      fails++;
      $display("FAIL idle_after_b2b: got %b %b %h, want 0 %b %h",
               rvalid, err, rdata, last_err, last_rdata);
    end
  endtask

  task automatic test_random();
    logic e;
    logic [31:0] rd;
    logic        r;
    logic        w;
    logic [3:0]  b;
    logic [31:0] a;
    logic [31:0] d;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 3) != 0;
      w = 1'($urandom_range(0, 1));
      b = 4'($urandom);
      a = 32'($urandom_range(0, 19) * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      d = $urandom;
      step(r, w, b, a, d);
      if (r) model(w, b, a, d, e, rd);
      tests++;
      if ({rvalid, err, rdata} !== {r, last_err, last_rdata}) begin
        fails++;
        $display("FAIL random[%0d] req=%b we=%b adr=%h: got %b %b %h, want %b %b %h",
                 i, r, w, a, rvalid, err, rdata, r, last_err, last_rdata);
      end
    end
  endtask

  task automatic test_reset_midsweep();
    int n;
    logic e;
    logic [31:0] rd;
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ready, rvalid, err, rdata} !== 35'd0) begin
      fails++;
      $display("FAIL reset_async: got ready=%b rvalid=%b err=%b rdata=%h, want all 0",
               ready, rvalid, err, rdata);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ready, rvalid, err, rdata} !== 35'd0) begin
      fails++;
      $display("FAIL reset_midsweep_out: got ready=%b rvalid=%b err=%b rdata=%h, want all 0",
               ready, rvalid, err, rdata);
    end
    @(posedge clk);
    #1;
    model_clear();
    rst_n = 1'b1;
    wait_ready(n);
    tests++;
    if (n != 16) begin
      fails++;
      $display("FAIL sweep_restart: ready low for %0d cycles, want 16", n);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 4'h0, 32'(i * 4), '0);
      model(1'b0, 4'h0, 32'(i * 4), '0, e, rd);
      tests++;
      if ({rvalid, err, rdata} !== {1'b1, e, rd}) begin
        fails++;
        $display("FAIL reclear_read[%0d]: got %b %b %h, want 1 %b %h", i, rvalid, err, rdata, e, rd);
      end
    end
  endtask

  task automatic test_reset_pending();
    int n;
    logic e;
    logic [31:0] rd;
    step(1'b1, 1'b1, 4'hF, 32'h8, 32'hA5A5A5A5);
    model(1'b1, 4'hF, 32'h8, 32'hA5A5A5A5, e, rd);
    step(1'b1, 1'b0, 4'h0, 32'h8, '0);
    model(1'b0, 4'h0, 32'h8, '0, e, rd);
    tests++;
    if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'hA5A5A5A5}) begin
      fails++;
      $display("FAIL pending_read: got %b %b %h, want 1 0 a5a5a5a5", rvalid, err, rdata);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ready, rvalid, err, rdata} !== 35'd0) begin
      fails++;
      $display("FAIL pending_drop: got ready=%b rvalid=%b err=%b rdata=%h, want all 0",
               ready, rvalid, err, rdata);
    end
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    rst_n = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      tests++;
      if (rvalid !== 1'b0) begin
        fails++;
        $display("FAIL sweep_stray_rvalid[%0d]: got %b, want 0", n, rvalid);
      end
    end
    tests++;
    if (n != 16) begin
      fails++;
      $display("FAIL sweep_after_pending: ready low for %0d cycles, want 16", n);
    end
    step(1'b1, 1'b0, 4'h0, 32'h8, '0);
    model(1'b0, 4'h0, 32'h8, '0, e, rd);
    tests++;
    if ({rvalid, err, rdata} !== {1'b1, e, rd}) begin
      fails++;
      $display("FAIL read_after_pending: got %b %b %h, want 1 %b %h", rvalid, err, rdata, e, rd);
    end
    step(1'b0, 1'b0, 4'h0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_clear();
    test_directed();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_midsweep();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
